// File: rtl/tone_gen_pkg.sv
// Shared constants and the volume-to-amplitude table for the two-channel tone generator.
package tone_gen_pkg;
  localparam int          DIV_W   = 22;
  localparam int          NUM_CH  = 2;
  localparam logic [2:0]  VOL_MAX = 3'd5;
  localparam logic [2:0]  VOL_RST = 3'd3;

  typedef logic signed [15:0] sample_t;

  function automatic logic [15:0] amp_of(input logic [2:0] vol);
    case (vol)
      3'd1:    amp_of = 16'h0800;
      3'd2:    amp_of = 16'h1000;
      3'd3:    amp_of = 16'h2000;
      3'd4:    amp_of = 16'h3000;
      3'd5:    amp_of = 16'h3FFF;
      default: amp_of = 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/tone_gen_if.sv
// Control/sample bundle between the tone generator and its controller / speaker path.
interface tone_gen_if;
  import tone_gen_pkg::*;
  logic [DIV_W-1:0] div_left;
  logic [DIV_W-1:0] div_right;
  logic             vol_up;
  logic             vol_dn;
  logic             mute;
  logic [15:0]      audio_left;
  logic [15:0]      audio_right;
  logic [2:0]       volume;

  modport master (output div_left, div_right, vol_up, vol_dn, mute,
                  input  audio_left, audio_right, volume);
  modport slave  (input  div_left, div_right, vol_up, vol_dn, mute,
                  output audio_left, audio_right, volume);
endinterface

// File: rtl/tone_channel.sv
// One square-wave channel; a new divider is adopted only at a period wrap or while silent.
module tone_channel
  import tone_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_in,
  input  logic [15:0]      amp,
  input  logic             force_zero,
  output logic [15:0]      sample
);
  logic [DIV_W-1:0] cnt, div_q;
  logic             active, wrap, high;

  assign active = div_q >= DIV_W'(2);
  assign wrap   = cnt == div_q - DIV_W'(1);
  // Floor half: on odd dividers the high phase is the shorter one.
  assign high   = cnt < (div_q >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      div_q  <= '0;
      sample <= '0;
    end else begin
      if (!active) begin
        cnt   <= '0;
        div_q <= div_in;
      end else if (wrap) begin
        cnt   <= '0;
        div_q <= div_in;
      end else begin
        cnt   <= cnt + DIV_W'(1);
      end
      if (!active || force_zero) sample <= '0;
      else if (high)             sample <= amp;
      else                       sample <= ~amp + 16'd1;
    end
  end
endmodule

// File: rtl/tone_gen.sv
// Two-channel tone generator top: shared saturating volume, amplitude lookup and mute.
module tone_gen
  import tone_gen_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  tone_gen_if.slave bus
);
  logic [2:0]                   vol;
  logic [15:0]                  amp;
  logic                         force_zero;
  logic [NUM_CH-1:0][DIV_W-1:0] div;
  logic [NUM_CH-1:0][15:0]      sample;

  always_ff @(posedge clk) begin
    if (rst)                                             vol <= VOL_RST;
    else if (bus.vol_up && !bus.vol_dn && vol < VOL_MAX) vol <= vol + 3'd1;
    else if (bus.vol_dn && !bus.vol_up && vol != 3'd0)   vol <= vol - 3'd1;
  end

  assign amp        = amp_of(vol);
  assign force_zero = bus.mute || (vol == 3'd0);
  assign div[0]     = bus.div_left;
  assign div[1]     = bus.div_right;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tone_channel u_ch (
      .clk        (clk),
      .rst        (rst),
      .div_in     (div[c]),
      .amp        (amp),
      .force_zero (force_zero),
      .sample     (sample[c])
    );
  end

  assign bus.audio_left  = sample[0];
  assign bus.audio_right = sample[1];
  assign bus.volume      = vol;
endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: directed scenarios plus random stimulus against a period-queue model.
module tb_tone_gen;
  import tone_gen_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tone_gen_if ifc();
  tone_gen dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int n_chk  = 0;
  int n_fail = 0;

  // Model: each channel holds the remaining phases of its current period (1 = high).
  bit          ql[$], qr[$];
  logic [2:0]  m_vol;
  logic [15:0] exp_l, exp_r;

  function automatic logic [15:0] ref_amp(input int v);
    case (v)
      1: return 16'h0800;
      2: return 16'h1000;
      3: return 16'h2000;
      4: return 16'h3000;
      5: return 16'h3FFF;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [15:0] a;
    int dl, dr;
    dl = int'(ifc.div_left);
    dr = int'(ifc.div_right);
    if (rst) begin
      ql.delete(); qr.delete();
      m_vol = 3'd3; exp_l = 16'h0; exp_r = 16'h0;
    end else begin
      a = ref_amp(int'(m_vol));
      exp_l = (ql.size() > 0 && !ifc.mute) ? (ql[0] ? a : 16'h0 - a) : 16'h0;
      exp_r = (qr.size() > 0 && !ifc.mute) ? (qr[0] ? a : 16'h0 - a) : 16'h0;
      if (ql.size() > 0) void'(ql.pop_front());
      if (qr.size() > 0) void'(qr.pop_front());
      if (ql.size() == 0 && dl >= 2) for (int i = 0; i < dl; i++) ql.push_back(i < dl / 2);
      if (qr.size() == 0 && dr >= 2) for (int i = 0; i < dr; i++) qr.push_back(i < dr / 2);
      if (ifc.vol_up && !ifc.vol_dn && m_vol < 3'd5)      m_vol = m_vol + 3'd1;
      else if (ifc.vol_dn && !ifc.vol_up && m_vol > 3'd0) m_vol = m_vol - 3'd1;
    end
  end

  wire [34:0] got  = {ifc.audio_left, ifc.audio_right, ifc.volume};
  wire [34:0] want = {exp_l, exp_r, m_vol};

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.div_left = '0; ifc.div_right = '0;
    ifc.vol_up = 1'b0; ifc.vol_dn = 1'b0; ifc.mute = 1'b0;
    repeat (3) cyc();
    n_chk++;
    if (got !== {16'h0, 16'h0, 3'd3}) begin
      n_fail++; $display("FAIL reset: got %h required %h", got, {16'h0, 16'h0, 3'd3});
    end
  endtask

  task automatic test_div4();
    logic [15:0] pat;
    rst = 1'b0; ifc.div_left = 22'd4; ifc.div_right = 22'd0;
    cyc();
    n_chk++;
    if (ifc.audio_left !== 16'h0) begin
      n_fail++; $display("FAIL div4_first: got %h required 0000", ifc.audio_left);
    end
    for (int i = 0; i < 16; i++) begin
      cyc();
      pat = (i % 4 < 2) ? 16'h2000 : 16'hE000;
      n_chk++;
      if (ifc.audio_left !== pat || ifc.audio_right !== 16'h0 || got !== want) begin
        n_fail++; $display("FAIL div4[%0d]: got %h required L=%h model %h", i, got, pat, want);
      end
    end
  endtask

  task automatic test_div_change();
    int pos;
    ifc.div_left = 22'd5;
    for (int i = 0; i < 23; i++) begin
      cyc();
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL div5[%0d]: got %h required %h", i, got, want); end
    end
    ifc.div_left = 22'd8;
    pos = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL div8[%0d]: got %h required %h", i, got, want); end
      if (ifc.audio_left == 16'h2000) pos++;
    end
    // 30 cycles: at most 4 of the old 5-period left, then >=3 full 8-cycle periods (4 high each).
    n_chk++;
    if (pos < 12) begin n_fail++; $display("FAIL div8_highs: got %0d required >=12", pos); end
  endtask

  task automatic test_vol_up();
    logic [2:0] exp_v [6] = '{3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5};
    for (int i = 0; i < 6; i++) begin
      ifc.vol_up = 1'b1; cyc(); ifc.vol_up = 1'b0;
      n_chk++;
      if (ifc.volume !== exp_v[i] || got !== want) begin
        n_fail++; $display("FAIL vol_up[%0d]: got %h vol %0d required vol %0d", i, got, ifc.volume, exp_v[i]);
      end
      cyc();
    end
    repeat (3) cyc();
    n_chk++;
    if ((ifc.audio_left !== 16'h3FFF && ifc.audio_left !== 16'hC001) || got !== want) begin
      n_fail++; $display("FAIL vol_max_amp: got %h required 3fff/c001 model %h", ifc.audio_left, want);
    end
  endtask

  task automatic test_vol_dn();
    logic [2:0] exp_v [6] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    for (int i = 0; i < 6; i++) begin
      ifc.vol_dn = 1'b1; cyc(); ifc.vol_dn = 1'b0;
      n_chk++;
      if (ifc.volume !== exp_v[i] || got !== want) begin
        n_fail++; $display("FAIL vol_dn[%0d]: got %h vol %0d required vol %0d", i, got, ifc.volume, exp_v[i]);
      end
    end
    ifc.div_right = 22'd3;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_chk++;
      if (ifc.audio_left !== 16'h0 || ifc.audio_right !== 16'h0 || got !== want) begin
        n_fail++; $display("FAIL vol0_silent[%0d]: got %h required 0 model %h", i, got, want);
      end
    end
  endtask

  task automatic test_both();
    repeat (2) begin ifc.vol_up = 1'b1; cyc(); ifc.vol_up = 1'b0; end
    ifc.vol_up = 1'b1; ifc.vol_dn = 1'b1; cyc();
    ifc.vol_up = 1'b0; ifc.vol_dn = 1'b0; cyc();
    n_chk++;
    if (ifc.volume !== 3'd2 || got !== want) begin
      n_fail++; $display("FAIL vol_both: got vol %0d required 2 (model %h got %h)", ifc.volume, want, got);
    end
  endtask

  task automatic test_mute();
    ifc.div_left = 22'd6; ifc.div_right = 22'd6;
    repeat (9) cyc();
    ifc.mute = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_chk++;
      if (ifc.audio_left !== 16'h0 || ifc.audio_right !== 16'h0) begin
        n_fail++; $display("FAIL mute[%0d]: got L=%h R=%h required 0", i, ifc.audio_left, ifc.audio_right);
      end
    end
    ifc.mute = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL unmute[%0d]: got %h required %h", i, got, want); end
    end
  endtask

  task automatic test_reset_mid();
    ifc.vol_up = 1'b1; cyc(); ifc.vol_up = 1'b0;
    repeat (2) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    n_chk++;
    if (got !== {16'h0, 16'h0, 3'd3}) begin
      n_fail++; $display("FAIL reset_mid: got %h required %h", got, {16'h0, 16'h0, 3'd3});
    end
    cyc();
    n_chk++;
    if (ifc.audio_left !== 16'h0) begin n_fail++; $display("FAIL restart_latch: got %h required 0000", ifc.audio_left); end
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_chk++;
      if (ifc.audio_left !== ((i % 6 < 3) ? 16'h2000 : 16'hE000) || got !== want) begin
        n_fail++; $display("FAIL restart[%0d]: got %h model %h", i, got, want);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) ifc.div_left  = 22'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) ifc.div_right = 22'($urandom_range(0, 12));
      ifc.vol_up = ($urandom_range(0, 9) == 0);
      ifc.vol_dn = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) ifc.mute = ~ifc.mute;
      cyc();
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL random[%0d]: got %h required %h", i, got, want); end
    end
    ifc.vol_up = 1'b0; ifc.vol_dn = 1'b0; ifc.mute = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_div4();
    test_div_change();
    test_vol_up();
    test_vol_dn();
    test_both();
    test_mute();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
